// File: rtl/dac0832_pkg.sv
// -----------------------------------------------------------------------------
// dac0832_pkg
// Shared definitions for the DAC0832 write controller:
//   - dac_state_e   : 3-bit controller state encoding
//   - DBL_BUF_EN    : 1 when built with DAC0832_DOUBLE_BUF_EN defined
//   - ns_to_cyc()   : nanoseconds to clock cycles, never less than 1
//   - calc_period() : clock cycles between accepted samples
// Build option: DAC0832_DOUBLE_BUF_EN selects double-buffered latch control.
// -----------------------------------------------------------------------------
package dac0832_pkg;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_SETUP = 3'd1,
        ST_WR1   = 3'd2,
        ST_GAP   = 3'd3,
        ST_XFER  = 3'd4,
        ST_RATE  = 3'd5
    } dac_state_e;

`ifdef DAC0832_DOUBLE_BUF_EN
    localparam logic DBL_BUF_EN = 1'b1;
`else
    localparam logic DBL_BUF_EN = 1'b0;
`endif

    localparam int unsigned PCNT_W = 32'd24;

    // Strobe and setup widths are rounded down but a zero-cycle pulse would
    // violate the datasheet, so clamp to one cycle.
    function automatic int unsigned ns_to_cyc(input int unsigned clk_mhz,
                                              input int unsigned ns);
        int unsigned c;
        c = (clk_mhz * ns) / 32'd1000;
        return (c == 32'd0) ? 32'd1 : c;
    endfunction

    function automatic int unsigned calc_period(input int unsigned clk_mhz,
                                                input int unsigned dac_hz);
        int unsigned p;
        p = (dac_hz == 32'd0) ? 32'd1 : ((32'd1_000_000 * clk_mhz) / dac_hz);
        return (p == 32'd0) ? 32'd1 : p;
    endfunction

endpackage

// File: rtl/dac0832_rate_timer.sv
// -----------------------------------------------------------------------------
// dac0832_rate_timer
// Saturating 24-bit cycle counter measuring time since the last restart.
//   clk     in  system clock
//   rst_n   in  asynchronous active-low reset
//   restart in  clear the count (asserted on the sample accept cycle)
//   expired out count has reached PERIOD-1
// -----------------------------------------------------------------------------
module dac0832_rate_timer
    import dac0832_pkg::*;
#(
    parameter int unsigned PERIOD = 32'd50000
) (
    input  logic clk,
    input  logic rst_n,
    input  logic restart,
    output logic expired
);

    // Limit is clamped to what the 24-bit counter can represent.
    localparam int unsigned LIM_I = (PERIOD > 32'd16777216) ? 32'd16777215 :
                                    ((PERIOD == 32'd0) ? 32'd0 : (PERIOD - 32'd1));
    localparam logic [PCNT_W-1:0] LIMIT   = PCNT_W'(LIM_I);
    localparam logic [PCNT_W-1:0] CNT_MAX = {PCNT_W{1'b1}};

    logic [PCNT_W-1:0] r_period_cnt;

    // Period counter: cleared on accept, then counts up and sticks at max.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_period_cnt <= '0;
        end else if (restart) begin
            r_period_cnt <= '0;
        end else if (r_period_cnt != CNT_MAX) begin
            r_period_cnt <= r_period_cnt + 24'd1;
        end else begin
            r_period_cnt <= r_period_cnt;
        end
    end

    assign expired = (r_period_cnt >= LIMIT);

endmodule

// File: rtl/dac0832_top.sv
// -----------------------------------------------------------------------------
// dac0832_top
// Write controller for a DAC0832 8-bit current-output DAC. Accepts one sample
// per valid/ready handshake, drives DI and the CS_n/WR1_n/XFER_n/WR2_n strobes
// with datasheet setup and pulse widths, and limits the update rate.
// Ports:
//   clk, rst_n (async active-low)
//   dac0832_valid/ready/data  sample handshake (ready = state is IDLE)
//   dac0832_done              one-cycle pulse when the DAC output is updated
//   dac0832_di[7:0]           DAC data bus
//   dac0832_cs_n, dac0832_wr1_n, dac0832_wr2_n, dac0832_xfer_n  strobes
//   dac0832_ile               input latch enable, tied high
//   dac0832_state[2:0]        current state, debug only
// Build option: DAC0832_DOUBLE_BUF_EN -> separate XFER/WR2 transfer pulse
// (GAP and XFER states). Undefined -> WR2_n/XFER_n held low, DAC latch
// transparent, WR1 alone updates the output.
// -----------------------------------------------------------------------------
module dac0832_top
    import dac0832_pkg::*;
#(
    parameter int unsigned CLK_FRE  = 32'd50,
    parameter int unsigned DAC_FRE  = 32'd1000,
    parameter int unsigned SETUP_NS = 32'd1000,
    parameter int unsigned WR_NS    = 32'd500
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       dac0832_valid,
    output logic       dac0832_ready,
    input  logic [7:0] dac0832_data,
    output logic       dac0832_done,
    output logic [7:0] dac0832_di,
    output logic       dac0832_cs_n,
    output logic       dac0832_wr1_n,
    output logic       dac0832_wr2_n,
    output logic       dac0832_xfer_n,
    output logic       dac0832_ile,
    output logic [2:0] dac0832_state
);

    localparam int unsigned SETUP_CYC = ns_to_cyc(CLK_FRE, SETUP_NS);
    localparam int unsigned WR_CYC    = ns_to_cyc(CLK_FRE, WR_NS);
    localparam int unsigned PERIOD    = calc_period(CLK_FRE, DAC_FRE);

    localparam logic [23:0] SETUP_LAST = 24'(SETUP_CYC - 32'd1);
    localparam logic [23:0] WR_LAST    = 24'(WR_CYC - 32'd1);

    // In single-buffered mode WR2_n/XFER_n idle low to keep the DAC latch open.
`ifdef DAC0832_DOUBLE_BUF_EN
    localparam logic WR2_IDLE = 1'b1;
`else
    localparam logic WR2_IDLE = 1'b0;
`endif

    dac_state_e  r_state;
    dac_state_e  w_state_nxt;
    logic [23:0] r_cnt;
    logic        w_accept;
    logic        w_expired;

    logic        r_cs_n;
    logic        r_wr1_n;
    logic        r_wr2_n;
    logic        r_xfer_n;
    logic        r_done;
    logic [7:0]  r_di;

    logic        w_cs_n_nxt;
    logic        w_wr1_n_nxt;
    logic        w_wr2_n_nxt;
    logic        w_xfer_n_nxt;
    logic        w_done_nxt;

    assign w_accept = (r_state == ST_IDLE) && dac0832_valid;

    dac0832_rate_timer #(
        .PERIOD (PERIOD)
    ) u_rate_timer (
        .clk     (clk),
        .rst_n   (rst_n),
        .restart (w_accept),
        .expired (w_expired)
    );

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Next-state logic; r_cnt holds cycles spent in the current state.
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            ST_IDLE: begin
                if (dac0832_valid) begin
                    w_state_nxt = ST_SETUP;
                end else begin
                    w_state_nxt = ST_IDLE;
                end
            end
            ST_SETUP: begin
                if (r_cnt == SETUP_LAST) begin
                    w_state_nxt = ST_WR1;
                end else begin
                    w_state_nxt = ST_SETUP;
                end
            end
            ST_WR1: begin
                if (r_cnt == WR_LAST) begin
`ifdef DAC0832_DOUBLE_BUF_EN
                    w_state_nxt = ST_GAP;
`else
                    w_state_nxt = ST_RATE;
`endif
                end else begin
                    w_state_nxt = ST_WR1;
                end
            end
`ifdef DAC0832_DOUBLE_BUF_EN
            ST_GAP: begin
                w_state_nxt = ST_XFER;
            end
            ST_XFER: begin
                if (r_cnt == WR_LAST) begin
                    w_state_nxt = ST_RATE;
                end else begin
                    w_state_nxt = ST_XFER;
                end
            end
`endif
            ST_RATE: begin
                if (w_expired) begin
                    w_state_nxt = ST_IDLE;
                end else begin
                    w_state_nxt = ST_RATE;
                end
            end
            default: begin
                w_state_nxt = ST_IDLE;
            end
        endcase
    end

    // Output decode of the next state, so the registered strobes line up
    // exactly with the state they belong to.
    always_comb begin
        w_cs_n_nxt   = 1'b1;
        w_wr1_n_nxt  = 1'b1;
        w_wr2_n_nxt  = WR2_IDLE;
        w_xfer_n_nxt = WR2_IDLE;
        w_done_nxt   = (w_state_nxt == ST_RATE) && (r_state != ST_RATE);
        case (w_state_nxt)
            ST_SETUP: begin
                w_cs_n_nxt = 1'b0;
            end
            ST_WR1: begin
                w_cs_n_nxt  = 1'b0;
                w_wr1_n_nxt = 1'b0;
            end
`ifdef DAC0832_DOUBLE_BUF_EN
            ST_GAP: begin
                w_cs_n_nxt = 1'b0;
            end
            ST_XFER: begin
                w_cs_n_nxt   = 1'b0;
                w_wr2_n_nxt  = 1'b0;
                w_xfer_n_nxt = 1'b0;
            end
`endif
            default: begin
                w_cs_n_nxt = 1'b1;
            end
        endcase
    end

    // In-state cycle counter, restarted on every state change.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_cnt <= 24'd0;
        end else if (w_state_nxt != r_state) begin
            r_cnt <= 24'd0;
        end else begin
            r_cnt <= r_cnt + 24'd1;
        end
    end

    // Strobe and done registers; async reset releases every strobe at once.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_cs_n   <= 1'b1;
            r_wr1_n  <= 1'b1;
            r_wr2_n  <= WR2_IDLE;
            r_xfer_n <= WR2_IDLE;
            r_done   <= 1'b0;
        end else begin
            r_cs_n   <= w_cs_n_nxt;
            r_wr1_n  <= w_wr1_n_nxt;
            r_wr2_n  <= w_wr2_n_nxt;
            r_xfer_n <= w_xfer_n_nxt;
            r_done   <= w_done_nxt;
        end
    end

    // Data bus register: loads only on the accept cycle.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_di <= 8'h00;
        end else if (w_accept) begin
            r_di <= dac0832_data;
        end else begin
            r_di <= r_di;
        end
    end

    assign dac0832_ready  = (r_state == ST_IDLE);
    assign dac0832_done   = r_done;
    assign dac0832_di     = r_di;
    assign dac0832_cs_n   = r_cs_n;
    assign dac0832_wr1_n  = r_wr1_n;
    assign dac0832_wr2_n  = r_wr2_n;
    assign dac0832_xfer_n = r_xfer_n;
    assign dac0832_ile    = 1'b1;
    assign dac0832_state  = r_state;

endmodule

// File: tb/tb_dac0832_top.sv
// -----------------------------------------------------------------------------
// tb_dac0832_top
// Scoreboard bench for dac0832_top. u_dut uses default timing (PERIOD=50000),
// u_fast uses PERIOD=60 to exercise back-to-back accepts. Stimulus pushes the
// expected accept cycle and latched byte; monitors pop on each CS_n fall and
// check strobe timing on each done pulse.
// -----------------------------------------------------------------------------
module tb_dac0832_top;
    import dac0832_pkg::*;

    localparam bit DB       = DBL_BUF_EN;
    localparam int SEQ      = DB ? 101 : 75;  // done offset from accept
    localparam int PER      = 50000;
    localparam int FAST_SPC = SEQ + 2;        // PERIOD=60 is below SEQ

    typedef struct {
        int         acc;
        logic [7:0] di;
    } exp_t;

    exp_t q_dut[$];
    exp_t q_fast[$];

    int n_chk  = 0;
    int n_pass = 0;
    int cyc    = 0;

    logic clk = 1'b0;

    logic       rst_n, valid, ready, done, cs_n, wr1_n, wr2_n, xfer_n, ile;
    logic [7:0] data, di;
    logic [2:0] state;

    logic       f_rst_n, f_valid, f_ready, f_done, f_cs_n, f_wr1_n, f_wr2_n, f_xfer_n, f_ile;
    logic [7:0] f_data, f_di;
    logic [2:0] f_state;

    dac0832_top #(.CLK_FRE(50), .DAC_FRE(1000), .SETUP_NS(1000), .WR_NS(500)) u_dut (
        .clk(clk), .rst_n(rst_n), .dac0832_valid(valid), .dac0832_ready(ready),
        .dac0832_data(data), .dac0832_done(done), .dac0832_di(di),
        .dac0832_cs_n(cs_n), .dac0832_wr1_n(wr1_n), .dac0832_wr2_n(wr2_n),
        .dac0832_xfer_n(xfer_n), .dac0832_ile(ile), .dac0832_state(state)
    );

    dac0832_top #(.CLK_FRE(50), .DAC_FRE(833333), .SETUP_NS(1000), .WR_NS(500)) u_fast (
        .clk(clk), .rst_n(f_rst_n), .dac0832_valid(f_valid), .dac0832_ready(f_ready),
        .dac0832_data(f_data), .dac0832_done(f_done), .dac0832_di(f_di),
        .dac0832_cs_n(f_cs_n), .dac0832_wr1_n(f_wr1_n), .dac0832_wr2_n(f_wr2_n),
        .dac0832_xfer_n(f_xfer_n), .dac0832_ile(f_ile), .dac0832_state(f_state)
    );

    always #5 clk = ~clk;

    initial begin
        forever begin
            @(posedge clk);
            cyc++;
        end
    end

    task automatic check(input string name, input int act, input int exp);
        n_chk++;
        if (act == exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    function automatic logic [7:0] g_dat(input int x);
        logic [31:0] t;
        t = x;
        return t[7:0] ^ 8'h5A;
    endfunction

    function automatic logic [7:0] h_dat(input int x);
        logic [31:0] t;
        t = x;
        return ~t[7:0];
    endfunction

    // Monitor for u_dut: accept/data on CS_n fall, strobe timing on done.
    initial begin
        logic p_cs, p_wr1, p_wr2, p_xf, busy, chk_low;
        int acc, wr1f, wr1r, wr2f, wr2r, xff, xfr, nz2, nzx;
        logic [7:0] cur_di;
        exp_t e;
        p_cs = 1'b1; p_wr1 = 1'b1; p_wr2 = DB; p_xf = DB; busy = 1'b0; chk_low = 1'b0;
        acc = 0; wr1f = -1; wr1r = -1; wr2f = -1; wr2r = -1; xff = -1; xfr = -1;
        nz2 = 0; nzx = 0; cur_di = 8'h00;
        forever begin
            @(negedge clk);
            if (!rst_n) begin
                busy = 1'b0;
                chk_low = 1'b0;
            end else begin
                if (chk_low) begin
                    check("dut_done_one_cycle", int'(done), 0);
                    chk_low = 1'b0;
                end
                if (p_cs && !cs_n) begin
                    check("dut_accept_expected", int'(q_dut.size() > 0), 1);
                    if (q_dut.size() > 0) begin
                        e = q_dut.pop_front();
                        check("dut_accept_cycle", cyc, e.acc);
                        check("dut_di_latched", int'(di), int'(e.di));
                        cur_di = e.di;
                    end
                    busy = 1'b1; acc = cyc;
                    wr1f = -1; wr1r = -1; wr2f = -1; wr2r = -1; xff = -1; xfr = -1;
                    nz2 = 0; nzx = 0;
                end
                if (busy) begin
                    if (p_wr1 && !wr1_n) wr1f = cyc - acc;
                    if (!p_wr1 && wr1_n) wr1r = cyc - acc;
                    if (p_wr2 && !wr2_n) wr2f = cyc - acc;
                    if (!p_wr2 && wr2_n) wr2r = cyc - acc;
                    if (p_xf && !xfer_n) xff = cyc - acc;
                    if (!p_xf && xfer_n) xfr = cyc - acc;
                    if (!done) begin
                        if (!wr2_n) nz2++;
                        if (!xfer_n) nzx++;
                    end else begin
                        check("dut_done_offset", cyc - acc, SEQ);
                        check("dut_di_hold", int'(di), int'(cur_di));
                        check("dut_cs_n_high_at_done", int'(cs_n), 1);
                        check("dut_wr1_fall", wr1f, 50);
                        check("dut_wr1_rise", wr1r, 75);
                        check("dut_wr2_fall", wr2f, DB ? 76 : -1);
                        check("dut_wr2_rise", wr2r, DB ? 101 : -1);
                        check("dut_xfer_fall", xff, DB ? 76 : -1);
                        check("dut_xfer_rise", xfr, DB ? 101 : -1);
                        check("dut_wr2_low_cycles", nz2, DB ? 25 : 75);
                        check("dut_xfer_low_cycles", nzx, DB ? 25 : 75);
                        busy = 1'b0;
                        chk_low = 1'b1;
                    end
                end else if (done) begin
                    check("dut_done_inside_sequence", 0, 1);
                end
            end
            p_cs = cs_n; p_wr1 = wr1_n; p_wr2 = wr2_n; p_xf = xfer_n;
        end
    end

    // Monitor for u_fast: accept spacing and latched data.
    int f_dones = 0;
    initial begin
        logic p_cs;
        exp_t e;
        p_cs = 1'b1;
        forever begin
            @(negedge clk);
            if (f_rst_n) begin
                if (p_cs && !f_cs_n) begin
                    check("fast_accept_expected", int'(q_fast.size() > 0), 1);
                    if (q_fast.size() > 0) begin
                        e = q_fast.pop_front();
                        check("fast_accept_cycle", cyc, e.acc);
                        check("fast_di_latched", int'(f_di), int'(e.di));
                    end
                end
                if (f_done) f_dones++;
            end
            p_cs = f_cs_n;
        end
    end

    // Stimulus for u_fast: valid held high, data changing every cycle.
    initial begin
        int e0;
        f_rst_n = 1'b0; f_valid = 1'b0; f_data = 8'h00;
        repeat (3) @(negedge clk);
        f_rst_n = 1'b1;
        @(negedge clk);
        e0 = cyc + 1;
        for (int k = 0; k < 4; k++) begin
            q_fast.push_back('{e0 + k * FAST_SPC, h_dat(e0 + k * FAST_SPC)});
        end
        f_valid = 1'b1;
        f_data  = h_dat(cyc + 1);
        while (cyc < e0 + 3 * FAST_SPC) begin
            @(negedge clk);
            f_data = h_dat(cyc + 1);
        end
        f_valid = 1'b0;
    end

    // Main stimulus for u_dut.
    initial begin
        int acc1, acc2, acc3;
        rst_n = 1'b0; valid = 1'b0; data = 8'h00;
        @(negedge clk);
        @(negedge clk);
        check("rst_state", int'(state), int'(ST_IDLE));
        check("rst_di", int'(di), 0);
        check("rst_cs_n", int'(cs_n), 1);
        check("rst_wr1_n", int'(wr1_n), 1);
        check("rst_wr2_n", int'(wr2_n), DB ? 1 : 0);
        check("rst_xfer_n", int'(xfer_n), DB ? 1 : 0);
        check("rst_done", int'(done), 0);
        check("rst_ile", int'(ile), 1);
        check("rst_ready", int'(ready), 1);
        rst_n = 1'b1;
        @(negedge clk);

        // Single write of 8'hA5.
        acc1 = cyc + 1;
        q_dut.push_back('{acc1, 8'hA5});
        valid = 1'b1; data = 8'hA5;
        @(negedge clk);
        valid = 1'b0; data = 8'h00;

        // New data pulsed during WR1 must be ignored.
        while (cyc < acc1 + 60) @(negedge clk);
        valid = 1'b1; data = 8'hFF;
        @(negedge clk);
        valid = 1'b0;
        @(negedge clk);
        check("ign_state_wr1", int'(state), int'(ST_WR1));
        check("ign_di", int'(di), 8'hA5);
        check("ign_ready_low", int'(ready), 0);

        // Valid held with data changing every cycle: next accept one cycle
        // after RATE ends, i.e. PERIOD+1 after the first accept.
        while (cyc < acc1 + 200) @(negedge clk);
        acc2 = acc1 + PER + 1;
        q_dut.push_back('{acc2, g_dat(acc2)});
        valid = 1'b1;
        data  = g_dat(cyc + 1);
        while (cyc < acc2) begin
            @(negedge clk);
            data = g_dat(cyc + 1);
        end
        valid = 1'b0;

        // Asynchronous reset in the middle of WR1, between clock edges.
        while (cyc < acc2 + 60) @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        check("async_cs_n", int'(cs_n), 1);
        check("async_wr1_n", int'(wr1_n), 1);
        check("async_di", int'(di), 0);
        check("async_ready", int'(ready), 1);
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        check("post_rst_state", int'(state), int'(ST_IDLE));
        check("post_rst_ready", int'(ready), 1);

        // Second full write after reset, data 8'h3C.
        acc3 = cyc + 1;
        q_dut.push_back('{acc3, 8'h3C});
        valid = 1'b1; data = 8'h3C;
        @(negedge clk);
        valid = 1'b0;
        while (cyc < acc3 + SEQ + 20) @(negedge clk);

        check("dut_queue_drained", q_dut.size(), 0);
        check("fast_queue_drained", q_fast.size(), 0);
        check("fast_done_count", f_dones, 4);
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
